io_input_conditioner: RTL
=========================

# io_input_conditioner

Producer side of the load/store unit's `io_input_bus`. It takes raw board switches (10) and active-low pushbuttons (4), synchronizes and debounces them, and latches sticky press events for the buttons. It drives the 14-bit bus the LSU samples for memory-mapped input reads. Sits at top level between the board pins and the LSU.

## Interface

- `DB_CYCLES`, default 50000: consecutive stable synchronized cycles required to accept a level change. Legal range 2 .. 2^CNT_W-1.
- `CNT_W`, default 16: width of each per-input debounce counter.

- `clock_i`  in  1  system clock.
- `reset_ni`  in  1  reset; **one clock; reset is asynchronous and active-low**.
- `sw_raw_i`  in  10  raw slide switches, asynchronous, 1 = on.
- `key_raw_i`  in  4  raw pushbuttons, asynchronous, active-low (0 = pressed).
- `event_clr_i`  in  4  per-key event clear, 1-cycle pulse from top-level store decode.
- `io_input_bus_o`  out  14  LSU input bus:
  - [9:0] debounced switches.
  - [13:10] sticky press flags for key[3:0].
- `key_level_o`  out  4  debounced key level, 1 = pressed.

## Operation

- **Synchronizer.** Each of the 14 inputs passes through a 2-flop synchronizer. Keys are inverted at the first flop input, so internally 1 = pressed.
  - Reset value of all synchronizer flops is 0 (switch off / key released).
- **Debounce.** Per input `i`: stable level `db[i]` and counter `cnt[i]`, both reset to 0. On each edge:
  - if `s2[i] == db[i]`: `cnt[i] <= 0`.
  - else if `cnt[i] == DB_CYCLES-1`: `db[i] <= s2[i]`, `cnt[i] <= 0`.
  - else: `cnt[i] <= cnt[i]+1`.
  - Any return to the old level before acceptance zeroes the counter, so bounces shorter than `DB_CYCLES` are rejected.
  - The counter never wraps; its maximum value is `DB_CYCLES-1`.
- **Press events.** Flag `ev[k]` is set on the edge where `db` for key `k` goes 0->1.
  - A release (1->0) never sets the flag.
  - `ev[k]` clears on an edge where `event_clr_i[k]` = 1.
  - Simultaneous set and clear on the same edge: set wins and the flag stays 1.
  - Clearing an already-clear flag has no effect.
- **Outputs.** All outputs are registered with no combinational path from inputs.
  - `io_input_bus_o` = {ev[3:0], db_sw[9:0]}.
  - `key_level_o` = db_key[3:0].
- **Reset.** `reset_ni` low asynchronously forces all flops to 0, so all outputs are 0 immediately without a clock edge.
  - Reset asserted mid-count discards the partial count.
  - No event is generated at reset release, even if a key is held. A key held through reset is accepted as pressed after a full debounce, and that acceptance does set `ev`.

## Timing

- Edge 1 is the first clock edge sampling a new raw level, which is then held stable:
  - s1 updates at edge 1.
  - s2 updates at edge 2.
  - `cnt` reaches `DB_CYCLES-1` at edge `DB_CYCLES+1`.
  - `db` (and `ev` for a press) updates at edge `DB_CYCLES+2`.
- Total latency from raw change to output is `DB_CYCLES+2` edges, ±1 for synchronizer sampling uncertainty.
- `event_clr_i` takes effect at the edge it is sampled. The flag reads 0 from the next cycle.
- Throughput: one accepted transition per input per `DB_CYCLES+1` cycles at most.
- The LSU adds its own one-cycle register on this bus; that cycle is not counted here.

## Test plan

Use `DB_CYCLES` = 4.

1. **Reset.** Apply `reset_ni` = 0 with `key_raw_i` = 4'hF and `sw_raw_i` = 0, then release.
   -> `io_input_bus_o` = 14'h0 and `key_level_o` = 0 during and after reset. No flags set over 20 cycles.
2. **Switch latency.** Set `sw_raw_i[3]` 0->1 before edge 1 and hold.
   -> `io_input_bus_o[3]` is 0 through edge 5 and 1 after edge 6. No other bits change.
3. **Bounce rejection.** Drive `key_raw_i[0]` low 3 cycles, high 1, low 2, high 1, then low and held.
   -> `ev[0]` and `key_level_o[0]` stay 0 during the bounce, then rise together exactly `DB_CYCLES+2` edges after the final low. `io_input_bus_o[10]` = 1, set exactly once.
4. **Sticky flag and clear race.**
   - Press and release `key_raw_i[2]` -> `io_input_bus_o[12]` stays 1 after release and after `key_level_o[2]` returns to 0.
   - Pulse `event_clr_i[2]` -> bit reads 0 next cycle.
   - Re-press, aligning `event_clr_i[2]` with the acceptance edge -> bit remains 1.
5. **Asynchronous reset mid-count.** Start a `sw_raw_i[9]` change and drop `reset_ni` between clock edges after 2 counted cycles.
   -> Outputs are 0 immediately. After release with the switch still on, bit 9 rises only after a full `DB_CYCLES+2` edges.
6. **Release behaviour.** With `ev[1]` cleared and key 1 held, release key 1.
   -> `key_level_o[1]` falls after `DB_CYCLES+2` edges, and `io_input_bus_o[11]` stays 0.

Source files
------------

// File: rtl/io_input_conditioner.sv
// Board switch/key conditioner: 2-flop sync, per-input debounce,
// sticky key-press flags driving the LSU input bus.
module io_input_conditioner #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic [9:0]  sw_raw_i,
  input  logic [3:0]  key_raw_i,
  input  logic [3:0]  event_clr_i,
  output logic [13:0] io_input_bus_o,
  output logic [3:0]  key_level_o
);

  localparam int N = 14;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic [N-1:0] raw;
  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] db;
  logic [N-1:0] acc;
  logic [3:0]   ev;
  logic [3:0]   press;

  // keys are flipped here so every internal bit reads 1 = active
  assign raw = {~key_raw_i, sw_raw_i};

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             same;

    assign same   = (s2[i] == db[i]);
    assign acc[i] = !same && (cnt == LAST);

    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
        db[i] <= 1'b0;
        cnt   <= '0;
      end else begin
        unique case (1'b1)
          same: begin
            cnt <= '0;
          end
          acc[i]: begin
            db[i] <= s2[i];
            cnt   <= '0;
          end
          default: begin
            cnt <= cnt + CNT_W'(1);
          end
        endcase
      end
    end
  end

  // a press is an acceptance whose new level is 1
  assign press = acc[13:10] & s2[13:10];

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ev <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (press[k]) begin
          ev[k] <= 1'b1;
        end else if (event_clr_i[k]) begin
          ev[k] <= 1'b0;
        end
      end
    end
  end

  assign io_input_bus_o = {ev, db[9:0]};
  assign key_level_o    = db[13:10];

endmodule
